// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// ----------------------------------------------------------------------------
// 640x480@60 Hz VGA raster timing generator running from the 50 MHz system
// clock. A divide-by-two clock enable (pixel_ce) forms the 25 MHz pixel rate.
// The scan counters drawX/drawY address the colour palette's background
// memory. The sync and blank strobes are delayed by SYNC_DELAY pixel ticks so
// that they line up with the palette's registered (1-clock) memory read.
//
// Ports:
//   Clk         in   system clock, 50 MHz
//   Reset_n     in   asynchronous active-low reset
//   pixel_ce    out  pixel clock enable, high every other Clk
//   drawX       out  horizontal count, 0..H_TOTAL-1
//   drawY       out  vertical count, 0..V_TOTAL-1
//   hs          out  horizontal sync, active low, delayed SYNC_DELAY ticks
//   vs          out  vertical sync, active low, delayed SYNC_DELAY ticks
//   blank       out  1 = visible pixel, delayed SYNC_DELAY ticks
//   frame_start out  one-Clk pulse when the raster wraps to (0,0)
// ----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic       pixel_ce,
  output logic [9:0] drawX,
  output logic [9:0] drawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic       pixel_ce_r;
  logic [9:0] drawx_r;
  logic [9:0] drawy_r;
  logic       frame_start_r;
  logic       hs_raw_s;
  logic       vs_raw_s;
  logic       blank_raw_s;
  logic       frame_wrap_s;

  // Last pixel of the last line: the next tick is the frame boundary.
  assign frame_wrap_s = (drawx_r == H_LAST) && (drawy_r == V_LAST);

  // Divide-by-two pixel enable; first edge after reset release sets it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pixel_ce_r <= 1'b0;
    end else begin
      pixel_ce_r <= ~pixel_ce_r;
    end
  end

  // Raster scan counters, advancing only on pixel ticks.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      drawx_r <= 10'd0;
      drawy_r <= 10'd0;
    end else if (pixel_ce_r) begin
      if (drawx_r == H_LAST) begin
        drawx_r <= 10'd0;
        if (drawy_r == V_LAST) begin
          drawy_r <= 10'd0;
        end else begin
          drawy_r <= drawy_r + 10'd1;
        end
      end else begin
        drawx_r <= drawx_r + 10'd1;
      end
    end
  end

  // Frame pulse: high for the single Clk following the wrap to (0,0).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= pixel_ce_r && frame_wrap_s;
    end
  end

  // Undelayed sync/blank decode straight from the counter registers.
  always_comb begin
    hs_raw_s    = 1'b1;
    vs_raw_s    = 1'b1;
    blank_raw_s = 1'b0;
    if ((drawx_r >= H_SYNC_START) && (drawx_r < H_SYNC_END)) begin
      hs_raw_s = 1'b0;
    end else begin
      hs_raw_s = 1'b1;
    end
    if ((drawy_r >= V_SYNC_START) && (drawy_r < V_SYNC_END)) begin
      vs_raw_s = 1'b0;
    end else begin
      vs_raw_s = 1'b1;
    end
    if ((drawx_r < H_VIS_END) && (drawy_r < V_VIS_END)) begin
      blank_raw_s = 1'b1;
    end else begin
      blank_raw_s = 1'b0;
    end
  end

  // Strobe alignment: zero delay passes the decode straight through,
  // otherwise a shift register clocked on pixel ticks.
  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hs    = hs_raw_s;
      assign vs    = vs_raw_s;
      assign blank = blank_raw_s;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe_r;
      logic [SYNC_DELAY-1:0] vs_pipe_r;
      logic [SYNC_DELAY-1:0] blank_pipe_r;

      // Delay stages load idle values on reset and shift once per tick.
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          hs_pipe_r    <= {SYNC_DELAY{1'b1}};
          vs_pipe_r    <= {SYNC_DELAY{1'b1}};
          blank_pipe_r <= {SYNC_DELAY{1'b0}};
        end else if (pixel_ce_r) begin
          hs_pipe_r[0]    <= hs_raw_s;
          vs_pipe_r[0]    <= vs_raw_s;
          blank_pipe_r[0] <= blank_raw_s;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe_r[i]    <= hs_pipe_r[i-1];
            vs_pipe_r[i]    <= vs_pipe_r[i-1];
            blank_pipe_r[i] <= blank_pipe_r[i-1];
          end
        end
      end

      assign hs    = hs_pipe_r[SYNC_DELAY-1];
      assign vs    = vs_pipe_r[SYNC_DELAY-1];
      assign blank = blank_pipe_r[SYNC_DELAY-1];
    end
  endgenerate

  assign pixel_ce    = pixel_ce_r;
  assign drawX       = drawx_r;
  assign drawY       = drawy_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Full 800-pixel lines; the frame is shortened to
// 19 lines (12 visible, sync on lines 14..15) so that two frames and several
// randomly placed resets fit in a short run. The reference model derives
// every output from the number of Clk edges since reset release.
module tb_vga_timing_gen;

  localparam int H_VISIBLE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int V_VISIBLE = 12,  V_FP = 2,  V_SYNC = 2,  V_BP = 3;
  localparam int DLY     = 1;
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int FRAME   = H_TOTAL * V_TOTAL;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       pixel_ce, hs, vs, blank, frame_start;
  logic [9:0] drawX, drawY;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit meas_en = 1'b0;

  // measurement state (negedge process only)
  int hs_low = 0, hs_fall_cyc = 0, vs_low = 0, blank_hi = 0;
  int fs_cyc = 0, fs_count = 0, x799_run = 0;
  bit hs_fall_seen = 1'b0, fs_seen = 1'b0;
  int prev_x = 0, prev_y = 0, prev_hs = 1, prev_vs = 1;

  vga_timing_gen #(
    .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_DELAY(DLY)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pixel_ce(pixel_ce),
    .drawX(drawX), .drawY(drawY), .hs(hs), .vs(vs), .blank(blank),
    .frame_start(frame_start)
  );

  always #10 Clk = ~Clk;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t, cyc=%0d)", name, actual, expected, $time, cyc);
    end
  endtask

  // Reference: outputs as a pure function of Clk edges since release.
  function automatic void model(input int cc, output int pce, output int x, output int y,
                                output int h, output int v, output int b, output int fs);
    int t, p, q, qx, qy;
    t   = cc / 2;             // pixel ticks completed (ticks on even edges)
    p   = t % FRAME;
    pce = cc % 2;
    x   = p % H_TOTAL;
    y   = p / H_TOTAL;
    if (t >= DLY) begin
      q  = (t - DLY) % FRAME;
      qx = q % H_TOTAL;
      qy = q / H_TOTAL;
      h  = (qx >= H_VISIBLE + H_FP && qx < H_VISIBLE + H_FP + H_SYNC) ? 0 : 1;
      v  = (qy >= V_VISIBLE + V_FP && qy < V_VISIBLE + V_FP + V_SYNC) ? 0 : 1;
      b  = (qx < H_VISIBLE && qy < V_VISIBLE) ? 1 : 0;
    end else begin
      h = 1; v = 1; b = 0;
    end
    fs = (cc != 0 && cc % 2 == 0 && p == 0) ? 1 : 0;
  endfunction

  // Edge counter since reset release
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Per-cycle compare against the model, plus interval measurements
  always @(negedge Clk) begin
    int e_pce, e_x, e_y, e_h, e_v, e_b, e_fs;
    model(cyc, e_pce, e_x, e_y, e_h, e_v, e_b, e_fs);
    check("pixel_ce",    int'(pixel_ce),    e_pce);
    check("drawX",       int'(drawX),       e_x);
    check("drawY",       int'(drawY),       e_y);
    check("hs",          int'(hs),          e_h);
    check("vs",          int'(vs),          e_v);
    check("blank",       int'(blank),       e_b);
    check("frame_start", int'(frame_start), e_fs);

    if (meas_en) begin
      if (!hs) hs_low++;
      if (hs && prev_hs == 0) begin
        check("hs_low_clks", hs_low, 192);
        check("hs_rise_x", int'(drawX), 753);
        hs_low = 0;
      end
      if (!hs && prev_hs == 1) begin
        check("hs_fall_x", int'(drawX), 657);
        if (hs_fall_seen) check("hs_period_clks", cyc - hs_fall_cyc, 1600);
        hs_fall_seen = 1'b1;
        hs_fall_cyc  = cyc;
      end
      if (!vs) vs_low++;
      if (!vs && prev_vs == 1) begin
        check("vs_fall_y", int'(drawY), 14);
        check("vs_fall_x", int'(drawX), 1);
      end
      if (vs && prev_vs == 0) begin
        check("vs_low_clks", vs_low, 3200);
        vs_low = 0;
      end
      blank_hi += int'(blank);
      if (frame_start) begin
        check("fs_xy", int'(drawX) + int'(drawY), 0);
        if (fs_seen) begin
          check("fs_period_clks", cyc - fs_cyc, 30400);
          check("blank_hi_clks", blank_hi, 15360);
        end
        fs_seen  = 1'b1;
        fs_cyc   = cyc;
        blank_hi = 0;
        fs_count++;
      end
      if (drawX == 10'd799) begin
        x799_run++;
      end else if (x799_run != 0) begin
        check("x799_hold_clks", x799_run, 2);
        x799_run = 0;
      end
      if (prev_x == 799 && prev_y == 5 && drawX != 10'd799) begin
        check("row_wrap_x", int'(drawX), 0);
        check("row_wrap_y", int'(drawY), 6);
      end
    end
    prev_x  = int'(drawX);
    prev_y  = int'(drawY);
    prev_hs = int'(hs);
    prev_vs = int'(vs);
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_pixel_ce"},    int'(pixel_ce),    0);
    check({tag, "_drawX"},       int'(drawX),       0);
    check({tag, "_drawY"},       int'(drawY),       0);
    check({tag, "_hs"},          int'(hs),          1);
    check({tag, "_vs"},          int'(vs),          1);
    check({tag, "_blank"},       int'(blank),       0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
  endtask

  initial begin
    bit found;
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    check_reset_values("por");
    #3 Reset_n = 1'b1;
    meas_en = 1'b1;

    // first four Clks after release
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("start_pce",   int'(pixel_ce), (i % 2 == 0) ? 1 : 0);
      check("start_drawX", int'(drawX),    (i + 1) / 2);
      check("start_hs",    int'(hs),       1);
      check("start_vs",    int'(vs),       1);
      check("start_blank", int'(blank),    (i >= 1) ? 1 : 0);
    end

    // two full frames
    found = 1'b0;
    for (int i = 0; i < 70000 && !found; i++) begin
      @(negedge Clk);
      if (fs_count >= 2) found = 1'b1;
    end
    check("two_frames_seen", int'(found), 1);
    meas_en = 1'b0;

    // reset mid-frame at (300,10), between edges
    found = 1'b0;
    for (int i = 0; i < 40000 && !found; i++) begin
      @(negedge Clk);
      if (drawX == 10'd300 && drawY == 10'd10) found = 1'b1;
    end
    check("reach_300_10", int'(found), 1);
    @(posedge Clk);
    #4 Reset_n = 1'b0;
    #1 check_reset_values("mid");
    repeat (2) @(negedge Clk);
    #3 Reset_n = 1'b1;
    repeat (300) @(negedge Clk);

    // randomly placed asynchronous resets
    repeat (2) begin
      repeat ($urandom_range(100, 2000)) @(negedge Clk);
      @(posedge Clk);
      #($urandom_range(1, 8)) Reset_n = 1'b0;
      #1 check_reset_values("rnd");
      repeat ($urandom_range(1, 3)) @(negedge Clk);
      #($urandom_range(1, 8)) Reset_n = 1'b1;
    end
    repeat (1700) @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
